// File: rtl/acc_pkg.sv
// Shared definitions for the streaming frame accumulator.
// Holds the two-state FSM encoding and the default operand width and frame length.
package acc_pkg;

  localparam int unsigned DEF_N     = 8;
  localparam int unsigned DEF_COUNT = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/acc_frame_adder_rca.sv
// N-bit ripple-carry adder (purely combinational).
// Ports:
//   a, b  : N-bit operands
//   cin   : carry in
//   sum   : N-bit sum, modulo 2^N
//   cout  : carry out of the most significant bit
module RippleCarryAdder_nBit #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  // Full-adder chain, carry rippling from LSB to MSB.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < N; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[N];

endmodule

// File: rtl/acc_frame_adder.sv
// Streaming frame accumulator: sums up to COUNT N-bit operands per frame, one
// addition per cycle through a ripple-carry adder, then presents the total.
// Optional feature: define ACC_SATURATE_EN to clamp the total at all-ones on
// any carry-out; otherwise the total wraps modulo 2^N.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake; in_data operand, in_last ends frame
//   out_valid/out_ready   : result handshake
//   out_sum               : frame total
//   out_carry             : sticky carry-out seen anywhere in the frame
//   out_count             : operands in the frame (1..COUNT)
module acc_frame_adder
  import acc_pkg::*;
#(
  parameter  int unsigned N     = DEF_N,
  parameter  int unsigned COUNT = DEF_COUNT,
  localparam int unsigned CW    = $clog2(COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic          out_carry,
  output logic [CW-1:0] out_count
);

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  add_sum;
  logic          add_cout;

  RippleCarryAdder_nBit #(.N(N)) u_adder (
    .a   (acc_q),
    .b   (in_data),
    .cin (1'b0),
    .sum (add_sum),
    .cout(add_cout)
  );

  // Next-state and accumulator update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone is a handshake.
        if (in_valid) begin
`ifdef ACC_SATURATE_EN
          // Once saturated, further adds carry or add zero, so it stays all-ones.
          acc_d = add_cout ? {N{1'b1}} : add_sum;
`else
          acc_d = add_sum;
`endif
          ovf_d = ovf_q | add_cout;
          cnt_d = cnt_q + CW'(1);
          if ((cnt_q == CW'(COUNT - 1)) || in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State, datapath and handshake flags; flags decode the next state so they are flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      in_ready  <= (state_d == ACCUM);
      out_valid <= (state_d == HOLD);
    end
  end

  assign out_sum   = acc_q;
  assign out_carry = ovf_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_acc_frame_adder.sv
// Self-checking bench for acc_frame_adder: a COUNT=4 and a COUNT=1 instance share
// one directed stimulus stream; a per-instance frame model predicts handshakes
// and results every cycle, and literal expectations pin key results.
// Define ACC_SATURATE_EN for both RTL and bench to exercise saturation.
module tb_acc_frame_adder;

`ifdef ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic       o_ready [2];
  logic       o_valid [2];
  logic [7:0] o_sum   [2];
  logic       o_carry [2];
  logic [2:0] o_cnt0;
  logic [0:0] o_cnt1;

  int errors = 0;
  int checks = 0;

  // Model state per instance: running frame plus at most one pending result.
  int lim [2] = '{4, 1};
  int m_acc [2], m_cnt [2], p_sum [2], p_cnt [2];
  bit m_ovf [2], p_car [2], m_pend [2];
  // Last handshaken result observed on each instance.
  int hs_n [2], hs_sum [2], hs_cnt [2], hs_car [2];

  acc_frame_adder #(.N(8), .COUNT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[0]),
    .in_data(in_data), .in_last(in_last), .out_valid(o_valid[0]),
    .out_ready(out_ready), .out_sum(o_sum[0]), .out_carry(o_carry[0]),
    .out_count(o_cnt0)
  );

  acc_frame_adder #(.N(8), .COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ready[1]),
    .in_data(in_data), .in_last(in_last), .out_valid(o_valid[1]),
    .out_ready(out_ready), .out_sum(o_sum[1]), .out_carry(o_carry[1]),
    .out_count(o_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int cnt_of(input int k);
    return (k == 0) ? int'(o_cnt0) : int'(o_cnt1);
  endfunction

  // Frame model: integer sums, carry whenever a partial sum exceeds 255.
  always @(posedge clk) begin
    int t;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_pend[k] = 0;
      end else if (m_pend[k]) begin
        if (out_ready) begin
          m_pend[k] = 0;
          hs_n[k]++;
          hs_sum[k] = int'(o_sum[k]);
          hs_car[k] = int'(o_carry[k]);
          hs_cnt[k] = cnt_of(k);
        end
      end else if (in_valid) begin
        t = m_acc[k] + int'(in_data);
        if (t > 255) begin
          m_ovf[k] = 1;
          t = SAT ? 255 : t - 256;
        end
        m_acc[k] = t;
        m_cnt[k]++;
        if (m_cnt[k] == lim[k] || in_last) begin
          m_pend[k] = 1;
          p_sum[k] = m_acc[k]; p_car[k] = m_ovf[k]; p_cnt[k] = m_cnt[k];
          m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d_in_ready", k), int'(o_ready[k]), int'(!m_pend[k]));
        chk($sformatf("dut%0d_out_valid", k), int'(o_valid[k]), int'(m_pend[k]));
        if (m_pend[k]) begin
          chk($sformatf("dut%0d_out_sum", k), int'(o_sum[k]), p_sum[k]);
          chk($sformatf("dut%0d_out_carry", k), int'(o_carry[k]), int'(p_car[k]));
          chk($sformatf("dut%0d_out_count", k), cnt_of(k), p_cnt[k]);
        end
      end
    end
  end

  task automatic cyc(input bit v, input int d, input bit l, input bit r);
    in_valid  = v;
    in_data   = 8'(d);
    in_last   = l;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic frame4(input int a, input int b, input int c, input int d);
    cyc(1, a, 0, 1); cyc(1, b, 0, 1); cyc(1, c, 0, 1); cyc(1, d, 0, 1);
  endtask

  initial begin
    int n0, n1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d_in_ready", k), int'(o_ready[k]), 1);
      chk($sformatf("rst%0d_out_valid", k), int'(o_valid[k]), 0);
      chk($sformatf("rst%0d_out_sum", k), int'(o_sum[k]), 0);
      chk($sformatf("rst%0d_out_carry", k), int'(o_carry[k]), 0);
      chk($sformatf("rst%0d_out_count", k), cnt_of(k), 0);
    end

    // Full frame 10+20+30+40
    n0 = hs_n[0];
    frame4(10, 20, 30, 40);
    chk("t1_hold_valid", int'(o_valid[0]), 1);
    chk("t1_hold_ready", int'(o_ready[0]), 0);
    cyc(0, 0, 0, 1);
    chk("t1_ready_back", int'(o_ready[0]), 1);
    chk("t1_hs", hs_n[0], n0 + 1);
    chk("t1_sum", hs_sum[0], 100);
    chk("t1_carry", hs_car[0], 0);
    chk("t1_count", hs_cnt[0], 4);

    // Overflow 100+100+100+0
    frame4(100, 100, 100, 0);
    cyc(0, 0, 0, 1);
    chk("t2_sum", hs_sum[0], SAT ? 255 : 44);
    chk("t2_carry", hs_car[0], 1);
    chk("t2_count", hs_cnt[0], 4);

    // Early close, then next frame starts from zero
    cyc(1, 5, 0, 1); cyc(1, 7, 1, 1); cyc(0, 0, 0, 1);
    chk("t3_sum", hs_sum[0], 12);
    chk("t3_count", hs_cnt[0], 2);
    chk("t3_carry", hs_car[0], 0);
    frame4(1, 1, 1, 1);
    cyc(0, 0, 0, 1);
    chk("t3b_sum", hs_sum[0], 4);

    // Backpressure: result held, operands not consumed
    n0 = hs_n[0];
    frame4(1, 2, 3, 4);
    repeat (3) begin
      cyc(1, 9, 0, 0);
      chk("t4_stall_valid", int'(o_valid[0]), 1);
      chk("t4_stall_ready", int'(o_ready[0]), 0);
      chk("t4_stall_sum", int'(o_sum[0]), 10);
      chk("t4_stall_count", int'(o_cnt0), 4);
    end
    chk("t4_no_hs", hs_n[0], n0);
    cyc(1, 9, 0, 1);
    chk("t4_hs_sum", hs_sum[0], 10);
    chk("t4_ready_after", int'(o_ready[0]), 1);
    cyc(1, 9, 1, 1); cyc(0, 0, 0, 1);
    chk("t4_next_sum", hs_sum[0], 9);
    chk("t4_next_count", hs_cnt[0], 1);

    // Reset mid-frame discards the partial result
    n0 = hs_n[0];
    cyc(1, 3, 0, 1); cyc(1, 4, 0, 1);
    rst = 1'b1;
    cyc(0, 0, 0, 1);
    rst = 1'b0;
    chk("t5_no_hs", hs_n[0], n0);
    chk("t5_valid_low", int'(o_valid[0]), 0);
    frame4(1, 2, 3, 4);
    cyc(0, 0, 0, 1);
    chk("t5_sum", hs_sum[0], 10);
    chk("t5_count", hs_cnt[0], 4);
    chk("t5_hs", hs_n[0], n0 + 1);

    // COUNT=1 instance with in_valid held: 200 then 77 on alternate cycles
    rst = 1'b1;
    cyc(0, 0, 0, 1);
    rst = 1'b0;
    n1 = hs_n[1];
    cyc(1, 200, 0, 1);
    chk("t6_hold", int'(o_valid[1]), 1);
    cyc(1, 77, 0, 1);
    chk("t6_first_sum", hs_sum[1], 200);
    chk("t6_first_count", hs_cnt[1], 1);
    cyc(1, 77, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t6_second_sum", hs_sum[1], 77);
    chk("t6_second_count", hs_cnt[1], 1);
    chk("t6_hs", hs_n[1], n1 + 2);
    cyc(1, 0, 1, 1);
    cyc(0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
